// File: rtl/param_code_lock_if.sv
// Keypad-to-lock bus: digit strobe and programming request in, lock status out.
interface param_code_lock_if #(
  parameter int unsigned DIGIT_W   = 3,
  parameter int unsigned CODE_LEN  = 4,
  parameter int unsigned MAX_FAILS = 3
);
  localparam int unsigned IDX_W  = ($clog2(CODE_LEN) > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

  logic               in_valid;
  logic [DIGIT_W-1:0] in_digit;
  logic               prog_en;
  logic               locked;
  logic               entimer;
  logic               alarm;
  logic               prog_active;
  logic [IDX_W-1:0]   digit_idx;
  logic [FAIL_W-1:0]  fail_cnt;

  // Keypad/controller side
  modport master (
    output in_valid, in_digit, prog_en,
    input  locked, entimer, alarm, prog_active, digit_idx, fail_cnt
  );

  // Lock side
  modport slave (
    input  in_valid, in_digit, prog_en,
    output locked, entimer, alarm, prog_active, digit_idx, fail_cnt
  );
endinterface

// File: rtl/param_code_lock.sv
// Parametrised keypad code lock with failed-attempt lockout and in-field re-programming.
module param_code_lock #(
  parameter int unsigned                    DIGIT_W        = 3,
  parameter int unsigned                    CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]    DEFAULT_CODE   = 12'h688,
  parameter int unsigned                    UNLOCK_CYCLES  = 10,
  parameter int unsigned                    MAX_FAILS      = 3,
  parameter int unsigned                    LOCKOUT_CYCLES = 20
) (
  input  logic             clk,
  input  logic             reset,
  param_code_lock_if.slave bus
);

  localparam int unsigned IDX_W   = ($clog2(CODE_LEN) > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TMR_W   = ($clog2(TMR_MAX) > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_UNLOCK  = 2'd1,
    ST_PROG    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  typedef logic [CODE_LEN-1:0][DIGIT_W-1:0] code_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               err_q, err_n;
  logic [FAIL_W-1:0]  fail_q, fail_n;
  logic [TMR_W-1:0]   tmr_q, tmr_n;
  code_t              code_q, code_n;
  code_t              shadow_q, shadow_n;
  logic               locked_q, locked_n;
  logic               entimer_q, entimer_n;
  logic               alarm_q, alarm_n;
  logic               prog_q, prog_n;
  logic               last_digit;
  logic               err_all;

  assign last_digit = (idx_q == IDX_W'(CODE_LEN - 1));
  assign err_all    = err_q | (bus.in_digit != code_q[idx_q]);

  // State, datapath and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ENTRY;
      idx_q     <= '0;
      err_q     <= 1'b0;
      fail_q    <= '0;
      tmr_q     <= '0;
      code_q    <= code_t'(DEFAULT_CODE);
      shadow_q  <= '0;
      locked_q  <= 1'b1;
      entimer_q <= 1'b0;
      alarm_q   <= 1'b0;
      prog_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      err_q     <= err_n;
      fail_q    <= fail_n;
      tmr_q     <= tmr_n;
      code_q    <= code_n;
      shadow_q  <= shadow_n;
      locked_q  <= locked_n;
      entimer_q <= entimer_n;
      alarm_q   <= alarm_n;
      prog_q    <= prog_n;
    end
  end

  // Next-state, datapath update and output decode of the next state
  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    err_n    = err_q;
    fail_n   = fail_q;
    tmr_n    = tmr_q;
    code_n   = code_q;
    shadow_n = shadow_q;

    case (state_q)
      ST_ENTRY: begin
        // Mismatch is only accumulated; it is revealed after the last digit.
        if (bus.in_valid) begin
          if (!last_digit) begin
            idx_n = idx_q + IDX_W'(1);
            err_n = err_all;
          end else begin
            idx_n = '0;
            err_n = 1'b0;
            tmr_n = '0;
            if (!err_all) begin
              state_n = ST_UNLOCK;
              fail_n  = '0;
            end else if (fail_q == FAIL_W'(MAX_FAILS - 1)) begin
              state_n = ST_LOCKOUT;
              fail_n  = FAIL_W'(MAX_FAILS);
            end else begin
              fail_n = fail_q + FAIL_W'(1);
            end
          end
        end
      end
      ST_UNLOCK: begin
        if (bus.prog_en) begin
          state_n = ST_PROG;
          idx_n   = '0;
          tmr_n   = '0;
        end else if (tmr_q == TMR_W'(UNLOCK_CYCLES - 1)) begin
          state_n = ST_ENTRY;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr_q + TMR_W'(1);
        end
      end
      ST_PROG: begin
        // Dropping prog_en aborts, even on the cycle of the final digit.
        if (!bus.prog_en) begin
          state_n = ST_ENTRY;
          idx_n   = '0;
        end else if (bus.in_valid) begin
          shadow_n[idx_q] = bus.in_digit;
          if (last_digit) begin
            code_n  = shadow_n;
            state_n = ST_ENTRY;
            idx_n   = '0;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
      end
      ST_LOCKOUT: begin
        if (tmr_q == TMR_W'(LOCKOUT_CYCLES - 1)) begin
          state_n = ST_ENTRY;
          tmr_n   = '0;
          fail_n  = '0;
          idx_n   = '0;
        end else begin
          tmr_n = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_n = ST_ENTRY;
        idx_n   = '0;
        err_n   = 1'b0;
        tmr_n   = '0;
      end
    endcase

    locked_n  = (state_n == ST_ENTRY) || (state_n == ST_LOCKOUT);
    entimer_n = (state_n == ST_UNLOCK);
    alarm_n   = (state_n == ST_LOCKOUT);
    prog_n    = (state_n == ST_PROG);
  end

  assign bus.locked      = locked_q;
  assign bus.entimer     = entimer_q;
  assign bus.alarm       = alarm_q;
  assign bus.prog_active = prog_q;
  assign bus.digit_idx   = idx_q;
  assign bus.fail_cnt    = fail_q;

endmodule

// File: tb/tb_param_code_lock.sv
// Randomised and directed bench for param_code_lock against a digit-queue reference model.
module tb_param_code_lock;

  localparam int unsigned DW = 3;
  localparam int unsigned CL = 4;
  localparam int unsigned UC = 10;
  localparam int unsigned MF = 3;
  localparam int unsigned LC = 20;
  localparam logic [CL*DW-1:0] DEF = 12'h688;

  localparam int M_ENTRY = 0;
  localparam int M_OPEN  = 1;
  localparam int M_PROG  = 2;
  localparam int M_ALARM = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  param_code_lock_if #(.DIGIT_W(DW), .CODE_LEN(CL), .MAX_FAILS(MF)) bus();

  param_code_lock #(
    .DIGIT_W(DW), .CODE_LEN(CL), .DEFAULT_CODE(DEF),
    .UNLOCK_CYCLES(UC), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: keys typed so far, code as a digit array, remaining-cycle countdown
  int m_mode;
  int m_left;
  int m_fails;
  int m_code[CL];
  int m_keys[$];
  int m_new[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [CL*DW-1:0] mk(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic void model_reset();
    logic [CL*DW-1:0] dv;
    dv = DEF;
    m_mode  = M_ENTRY;
    m_left  = 0;
    m_fails = 0;
    for (int i = 0; i < CL; i++) m_code[i] = int'(dv[i*DW +: DW]);
    m_keys.delete();
    m_new.delete();
  endfunction

  function automatic void model_step(input bit v, input int d, input bit p);
    bit ok;
    case (m_mode)
      M_ENTRY: begin
        if (v) begin
          m_keys.push_back(d);
          if (m_keys.size() == CL) begin
            ok = 1'b1;
            for (int i = 0; i < CL; i++) if (m_keys[i] != m_code[i]) ok = 1'b0;
            m_keys.delete();
            if (ok) begin
              m_mode  = M_OPEN;
              m_left  = UC;
              m_fails = 0;
            end else begin
              m_fails++;
              if (m_fails == MF) begin
                m_mode = M_ALARM;
                m_left = LC;
              end
            end
          end
        end
      end
      M_OPEN: begin
        if (p) begin
          m_mode = M_PROG;
          m_new.delete();
        end else begin
          m_left--;
          if (m_left == 0) m_mode = M_ENTRY;
        end
      end
      M_PROG: begin
        if (!p) begin
          m_mode = M_ENTRY;
        end else if (v) begin
          m_new.push_back(d);
          if (m_new.size() == CL) begin
            for (int i = 0; i < CL; i++) m_code[i] = m_new[i];
            m_mode = M_ENTRY;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode  = M_ENTRY;
          m_fails = 0;
        end
      end
    endcase
  endfunction

  task automatic compare_all();
    int exp_idx;
    exp_idx = (m_mode == M_ENTRY) ? m_keys.size() : (m_mode == M_PROG) ? m_new.size() : 0;
    check("locked",      bus.locked,      32'((m_mode == M_ENTRY) || (m_mode == M_ALARM)));
    check("entimer",     bus.entimer,     32'(m_mode == M_OPEN));
    check("alarm",       bus.alarm,       32'(m_mode == M_ALARM));
    check("prog_active", bus.prog_active, 32'(m_mode == M_PROG));
    check("digit_idx",   bus.digit_idx,   32'(exp_idx));
    check("fail_cnt",    bus.fail_cnt,    32'(m_fails));
  endtask

  // Called at a falling edge: drive, clock once, sample at the next falling edge
  task automatic tick(input bit v, input int d, input bit p);
    bus.in_valid = v;
    bus.in_digit = DW'(d);
    bus.prog_en  = p;
    @(posedge clk);
    model_step(v, d, p);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic enter(input logic [CL*DW-1:0] cv, input bit p);
    for (int i = 0; i < CL; i++) tick(1'b1, int'(cv[i*DW +: DW]), p);
  endtask

  task automatic wait_open();
    int cnt;
    cnt = 0;
    while (bus.entimer === 1'b1 && cnt < 50) begin
      cnt++;
      tick(1'b1, int'($urandom_range(7)), 1'b0);
    end
    check("open_len", 32'(cnt), 32'(UC));
    check("relocked", bus.locked, 32'd1);
  endtask

  task automatic wait_alarm();
    int cnt;
    cnt = 0;
    while (bus.alarm === 1'b1 && cnt < 100) begin
      cnt++;
      tick(1'b1, int'($urandom_range(7)), 1'($urandom_range(1)));
    end
    check("alarm_len", 32'(cnt), 32'(LC));
    check("alarm_fail_clr", bus.fail_cnt, 32'd0);
  endtask

  // Called at a falling edge; reset rises between clock edges
  task automatic async_reset();
    bus.in_valid = 1'b0;
    bus.prog_en  = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("ar_locked",  bus.locked,      32'd1);
    check("ar_entimer", bus.entimer,     32'd0);
    check("ar_alarm",   bus.alarm,       32'd0);
    check("ar_prog",    bus.prog_active, 32'd0);
    check("ar_idx",     bus.digit_idx,   32'd0);
    check("ar_fail",    bus.fail_cnt,    32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CL*DW-1:0] c0123, c5123, c7654;
    logic [CL*DW-1:0] cur;
    bit p;
    c0123 = mk(0, 1, 2, 3);
    c5123 = mk(5, 1, 2, 3);
    c7654 = mk(7, 6, 5, 4);

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_digit = '0;
    bus.prog_en  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_locked",  bus.locked,      32'd1);
    check("rst_entimer", bus.entimer,     32'd0);
    check("rst_alarm",   bus.alarm,       32'd0);
    check("rst_prog",    bus.prog_active, 32'd0);
    check("rst_idx",     bus.digit_idx,   32'd0);
    check("rst_fail",    bus.fail_cnt,    32'd0);
    reset = 1'b0;

    // Default code with idle gaps
    for (int i = 0; i < CL; i++) begin
      tick(1'b1, i, 1'b0);
      check("idx_step", bus.digit_idx, 32'((i + 1) % CL));
      if (i == CL - 1) check("open_after_4th", bus.locked, 32'd0);
      else tick(1'b0, 0, 1'b0);
    end
    wait_open();
    check("fail_after_open", bus.fail_cnt, 32'd0);

    // Wrong first digit gives no early reaction
    for (int i = 0; i < CL; i++) begin
      check("no_early_alarm", bus.alarm, 32'd0);
      tick(1'b1, int'(c5123[i*DW +: DW]), 1'b0);
    end
    check("wrong_fail1", bus.fail_cnt, 32'd1);
    check("wrong_locked", bus.locked, 32'd1);
    check("wrong_alarm", bus.alarm, 32'd0);

    // Third consecutive wrong code triggers lockout
    enter(c5123, 1'b0);
    enter(c5123, 1'b0);
    check("lockout_alarm", bus.alarm, 32'd1);
    check("lockout_fail", bus.fail_cnt, 32'(MF));
    wait_alarm();
    enter(c0123, 1'b0);
    check("post_lockout_open", bus.locked, 32'd0);
    wait_open();

    // Two wrong then correct clears the count; single wrong after does not lock out
    enter(c5123, 1'b0);
    enter(c5123, 1'b0);
    check("two_wrong", bus.fail_cnt, 32'd2);
    enter(c0123, 1'b0);
    check("third_right_open", bus.locked, 32'd0);
    check("third_right_fail", bus.fail_cnt, 32'd0);
    wait_open();
    enter(c5123, 1'b0);
    check("single_wrong_fail", bus.fail_cnt, 32'd1);
    check("single_wrong_alarm", bus.alarm, 32'd0);
    enter(c0123, 1'b0);
    wait_open();

    // Programme a new code
    enter(c0123, 1'b0);
    tick(1'b0, 0, 1'b1);
    check("prog_enter", bus.prog_active, 32'd1);
    enter(c7654, 1'b1);
    tick(1'b0, 0, 1'b0);
    check("prog_done", bus.prog_active, 32'd0);
    check("prog_done_locked", bus.locked, 32'd1);
    enter(c0123, 1'b0);
    check("old_code_fails", bus.fail_cnt, 32'd1);
    enter(c7654, 1'b0);
    check("new_code_opens", bus.locked, 32'd0);
    wait_open();

    // Abort mid-entry, and abort on the final digit
    enter(c7654, 1'b0);
    tick(1'b0, 0, 1'b1);
    tick(1'b1, 0, 1'b1);
    tick(1'b1, 1, 1'b1);
    tick(1'b0, 0, 1'b0);
    check("abort_prog", bus.prog_active, 32'd0);
    enter(c7654, 1'b0);
    check("abort_keeps_code", bus.locked, 32'd0);
    tick(1'b0, 0, 1'b1);
    tick(1'b1, 0, 1'b1);
    tick(1'b1, 1, 1'b1);
    tick(1'b1, 2, 1'b1);
    tick(1'b1, 3, 1'b0);
    check("abort_final", bus.prog_active, 32'd0);
    enter(c7654, 1'b0);
    check("abort_final_keeps", bus.locked, 32'd0);
    wait_open();

    // Asynchronous reset during lockout
    repeat (MF) enter(c0123, 1'b0);
    check("lockout2", bus.alarm, 32'd1);
    repeat (5) tick(1'b0, 0, 1'b0);
    async_reset();
    enter(c0123, 1'b0);
    check("reset_restores_code", bus.locked, 32'd0);

    // Asynchronous reset during programming
    tick(1'b0, 0, 1'b1);
    tick(1'b1, 7, 1'b1);
    tick(1'b1, 6, 1'b1);
    async_reset();
    enter(c0123, 1'b0);
    check("reset_prog_code", bus.locked, 32'd0);
    wait_open();

    // Random traffic with occasional correct-code entries
    p = 1'b0;
    repeat (1500) begin
      if ($urandom_range(29) == 0) begin
        for (int i = 0; i < CL; i++) cur[i*DW +: DW] = DW'(m_code[i]);
        if ($urandom_range(1) == 0 && m_mode == M_ENTRY && m_keys.size() != 0)
          for (int i = m_keys.size(); i < CL; i++) tick(1'b1, 0, p);
        enter(cur, p);
      end else begin
        if ($urandom_range(9) == 0) p = ~p;
        tick($urandom_range(2) == 0, int'($urandom_range(7)), p);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
